// File: rtl/clock_tick_gen.sv
// clock_tick_gen: CLOCK_50 divider to a 50%-duty clk_slow plus tick, with run/pause
// and debounced single-step; define TICK_GEN_STEP_EN to build the step path.

module clock_tick_gen #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    input  logic step_n,
    output logic clk_slow,
    output logic tick,
    output logic running
);

    localparam int HALF = CLK_HZ / (2 * TICK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          run_meta_q, run_meta_d;
    logic          run_sync_q, run_sync_d;
    logic          press;
    logic          wrap;

    always_comb begin
        run_meta_d = run;
        run_sync_d = run_meta_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
        end else begin
            run_meta_q <= run_meta_d;
            run_sync_q <= run_sync_d;
        end
    end

`ifdef TICK_GEN_STEP_EN
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);

    logic          step_meta_q, step_meta_d;
    logic          step_sync_q, step_sync_d;
    logic          db_level_q, db_level_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;

    // Level follows the synced key only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        step_meta_d = step_n;
        step_sync_d = step_meta_q;
        db_level_d  = db_level_q;
        db_cnt_d    = '0;
        if (step_sync_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = step_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
        press = db_level_q & ~db_level_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            step_meta_q <= 1'b1;
            step_sync_q <= 1'b1;
            db_level_q  <= 1'b1;
            db_cnt_q    <= '0;
        end else begin
            step_meta_q <= step_meta_d;
            step_sync_q <= step_sync_d;
            db_level_q  <= db_level_d;
            db_cnt_q    <= db_cnt_d;
        end
    end
`else
    logic unused_step_n;

    assign unused_step_n = step_n;
    assign press         = 1'b0;
`endif

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        case (state_q)
            PAUSE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (run_sync_q) begin
                    state_d = RUN;
                end else if (press) begin
                    state_d = STEP;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                // A low phase may be cut short; a high phase always runs to its wrap.
                if (!run_sync_q && !clk_q) begin
                    state_d = PAUSE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                    if (!run_sync_q) begin
                        state_d = PAUSE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STEP: begin
                if (wrap) begin
                    state_d = PAUSE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = PAUSE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= PAUSE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_slow = clk_q;
    assign tick     = tick_q;
    assign running  = (state_q == RUN);

endmodule

// File: tb/tb_clock_tick_gen.sv
// tb_clock_tick_gen: directed scenarios plus random run/step/reset traffic,
// checked every cycle against a phase-age model of the timebase.

module tb_clock_tick_gen;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 1;
    localparam int DEB     = 4;
    localparam int H       = CLK_HZ / (2 * TICK_HZ);
`ifdef TICK_GEN_STEP_EN
    localparam int STEP_EN = 1;
`else
    localparam int STEP_EN = 0;
`endif

    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic run    = 1'b0;
    logic step_n = 1'b1;
    logic clk_slow;
    logic tick;
    logic running;

    int checks = 0;
    int errors = 0;

    clock_tick_gen #(
        .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .run(run),
        .step_n(step_n),
        .clk_slow(clk_slow),
        .tick(tick),
        .running(running)
    );

    always #5 clk = ~clk;

    // Model: mode plus age (cycles since the mode was entered).
    bit r1, r2, s1, s2, lvl;
    int dcnt, mode, age;
    bit e_clk, e_tick, e_run, mvalid;

    always @(posedge clk) begin : model
        bit press;
        bit hi;
        if (reset) begin
            r1 = 0; r2 = 0; s1 = 1; s2 = 1; lvl = 1;
            dcnt = 0; mode = M_PAUSE; age = 0;
            mvalid = 1;
        end else begin
            press = 0;
            if (STEP_EN != 0) begin
                if (s2 != lvl) begin
                    dcnt++;
                    if (dcnt == DEB) begin
                        lvl = s2;
                        dcnt = 0;
                        press = !lvl;
                    end
                end else begin
                    dcnt = 0;
                end
            end
            case (mode)
                M_PAUSE: begin
                    if (r2) begin
                        mode = M_RUN; age = 0;
                    end else if (press) begin
                        mode = M_STEP; age = 0;
                    end
                end
                M_RUN: begin
                    hi = ((age / H) % 2) == 1;
                    if (!r2 && (!hi || ((age + 1) % H) == 0)) begin
                        mode = M_PAUSE; age = 0;
                    end else begin
                        age++;
                    end
                end
                default: begin
                    if (age + 1 == H) begin
                        mode = M_PAUSE; age = 0;
                    end else begin
                        age++;
                    end
                end
            endcase
            r2 = r1; r1 = run;
            s2 = s1; s1 = step_n;
        end
        e_run = (mode == M_RUN);
        if (mode == M_RUN) begin
            e_clk  = ((age / H) % 2) == 1;
            e_tick = (age % (2 * H)) == H;
        end else if (mode == M_STEP) begin
            e_clk  = 1;
            e_tick = (age == 0);
        end else begin
            e_clk  = 0;
            e_tick = 0;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            check("model_clk_slow", clk_slow, e_clk);
            check("model_tick", tick, e_tick);
            check("model_running", running, e_run);
        end
    end

    task automatic count(input int n, output int t, output int h, output int r);
        t = 0; h = 0; r = 0;
        repeat (n) begin
            @(negedge clk);
            t += int'(tick);
            h += int'(clk_slow);
            r += int'(running);
        end
    endtask

    initial begin
        int t, h, r, ta, ha, ra;
        int run_hold, step_hold;
        bit found;

        reset = 1; run = 0; step_n = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        check_int("reset_clk_slow", int'(clk_slow), 0);
        check_int("reset_tick", int'(tick), 0);
        check_int("reset_running", int'(running), 0);

        // free-run start latency and period
        run = 1;
        repeat (2) @(negedge clk);
        check_int("run_lat2", int'(running), 0);
        @(negedge clk);
        check_int("run_lat3", int'(running), 1);
        repeat (9) @(negedge clk);
        check_int("first_rise_early", int'(clk_slow), 0);
        @(negedge clk);
        check_int("first_rise", int'(clk_slow), 1);
        check_int("first_tick", int'(tick), 1);
        count(100, t, h, r);
        check_int("ticks_100", t, 5);
        check_int("high_100", h, 50);

        // stop during high phase at cnt=3
        repeat (3) @(negedge clk);
        run = 0;
        repeat (6) @(negedge clk);
        check_int("stop_hold_clk", int'(clk_slow), 1);
        check_int("stop_hold_run", int'(running), 1);
        @(negedge clk);
        check_int("stop_fall_clk", int'(clk_slow), 0);
        check_int("stop_fall_run", int'(running), 0);
        count(50, t, h, r);
        check_int("paused_ticks", t, 0);
        check_int("paused_high", h, 0);

        // bouncy press while paused
        ta = 0; ha = 0; ra = 0;
        for (int i = 0; i < 6; i++) begin
            step_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            count(2, t, h, r);
            ta += t; ha += h; ra += r;
        end
        step_n = 0;
        count(30, t, h, r);
        ta += t; ha += h; ra += r;
        step_n = 1;
        count(10, t, h, r);
        ta += t; ha += h; ra += r;
        check_int("step_ticks", ta, STEP_EN);
        check_int("step_high", ha, 10 * STEP_EN);
        check_int("step_running", ra, 0);

        // presses while running are discarded
        run = 1;
        repeat (13) @(negedge clk);
        ta = 0; ha = 0;
        step_n = 0; count(8, t, h, r); ta += t; ha += h;
        step_n = 1; count(8, t, h, r); ta += t; ha += h;
        step_n = 0; count(8, t, h, r); ta += t; ha += h;
        step_n = 1; count(76, t, h, r); ta += t; ha += h;
        check_int("run_press_ticks", ta, 5);
        check_int("run_press_high", ha, 50);
        run = 0;
        count(30, t, h, r);
        check_int("run_stop_ticks", t, 0);
        ta = 0; ra = 0;
        for (int k = 0; k < 2; k++) begin
            step_n = 0; count(8, t, h, r); ta += t; ra += r;
            step_n = 1; count(20, t, h, r); ta += t; ra += r;
        end
        check_int("two_steps_ticks", ta, 2 * STEP_EN);
        check_int("two_steps_running", ra, 0);

        // reset in the middle of a high phase
        run = 1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (clk_slow) found = 1;
        end
        check_int("mid_reset_rise_seen", int'(found), 1);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_int("mid_reset_clk", int'(clk_slow), 0);
        check_int("mid_reset_tick", int'(tick), 0);
        check_int("mid_reset_run", int'(running), 0);
        reset = 0; run = 0;

        // random traffic
        run_hold = 0; step_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_hold == 0) begin
                run = 1'($urandom_range(0, 1));
                run_hold = int'($urandom_range(1, 120));
            end else begin
                run_hold--;
            end
            if (step_hold == 0) begin
                step_n = ($urandom_range(0, 3) != 0);
                step_hold = int'($urandom_range(1, 15));
            end else begin
                step_hold--;
            end
            reset = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        reset = 0; run = 0; step_n = 1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
